// File: rtl/ame_pivot_pkg.sv
// Shared types for the AME 6x6 pivot scheduler: row count, FSM states, column type.
package ame_pivot_pkg;

  localparam int AME_ROWS      = 6;
  localparam int AME_DATA_BITS = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_OUT,
    ST_DONE
  } state_t;

  typedef logic [AME_ROWS-1:0][AME_DATA_BITS-1:0] column_t;

endpackage

// File: rtl/ame_pivot_mat.sv
// Six-column coefficient store: write port only honoured while the scheduler idles,
// combinational column read. Contents survive reset.
module ame_pivot_mat
  import ame_pivot_pkg::*;
#(
  parameter int COMP_DATA_BITS     = 64,
  parameter int COMP_DATA_IDX_BITS = 3
) (
  input  logic                                    clk,
  input  logic                                    idle,
  input  logic                                    wr_en,
  input  logic [COMP_DATA_IDX_BITS-1:0]           wr_idx,
  input  logic [AME_ROWS-1:0][COMP_DATA_BITS-1:0] wr_data,
  input  logic [COMP_DATA_IDX_BITS-1:0]           rd_idx,
  output logic [AME_ROWS-1:0][COMP_DATA_BITS-1:0] rd_data
);

  logic [AME_ROWS-1:0][COMP_DATA_BITS-1:0] col_mem [AME_ROWS];
  logic [AME_ROWS-1:0]                     wr_sel;

  // Indices 6 and 7 match no column, so such writes fall away.
  for (genvar gi = 0; gi < AME_ROWS; gi++) begin : g_wr_sel
    assign wr_sel[gi] = idle && wr_en && (wr_idx == COMP_DATA_IDX_BITS'(gi));
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < AME_ROWS; i++) begin
      if (wr_sel[i]) col_mem[i] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < AME_ROWS; i++) begin
      if (rd_idx == COMP_DATA_IDX_BITS'(i)) rd_data = col_mem[i];
    end
  end

endmodule

// File: rtl/ame_pivot_sched.sv
// Sequential pivot scheduler for the AME 6x6 solve. Optional macro AME_PIVOT_PERM_EN
// adds the perm_o row-permutation output.
module ame_pivot_sched
  import ame_pivot_pkg::*;
#(
  parameter int COMP_DATA_BITS     = 64,
  parameter int COMP_DATA_IDX_BITS = 3
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic                                        col_wr_en_i,
  input  logic [COMP_DATA_IDX_BITS-1:0]               col_wr_idx_i,
  input  logic [AME_ROWS-1:0][COMP_DATA_BITS-1:0]     col_wr_data_i,
  input  logic                                        sched_init_i,
  output logic                                        sched_busy_o,
  output logic                                        sched_done_o,
  output logic                                        sched_singular_o,
  output logic                                        comp_init_o,
  output logic [AME_ROWS-1:0][COMP_DATA_BITS-1:0]     comp_data_o,
  output logic [AME_ROWS-1:0]                         comp_data_mask_o,
  input  logic                                        comp_done_i,
  input  logic [COMP_DATA_BITS-1:0]                   comp_data_i,
  input  logic [COMP_DATA_IDX_BITS-1:0]               comp_data_index_i,
`ifdef AME_PIVOT_PERM_EN
  output logic [AME_ROWS-1:0][COMP_DATA_IDX_BITS-1:0] perm_o,
`endif
  output logic                                        piv_valid_o,
  input  logic                                        piv_ready_i,
  output logic [COMP_DATA_IDX_BITS-1:0]               piv_col_o,
  output logic [COMP_DATA_IDX_BITS-1:0]               piv_row_o,
  output logic [COMP_DATA_BITS-1:0]                   piv_data_o
);

  localparam logic [COMP_DATA_IDX_BITS-1:0] LAST_COL = COMP_DATA_IDX_BITS'(AME_ROWS - 1);

  state_t                                  state_reg, state_next;
  logic [COMP_DATA_IDX_BITS-1:0]           col_cnt_reg;
  logic [AME_ROWS-1:0]                     mask_reg;
  logic                                    singular_reg;
  logic                                    piv_valid_reg;
  logic [COMP_DATA_IDX_BITS-1:0]           piv_col_reg;
  logic [COMP_DATA_IDX_BITS-1:0]           piv_row_reg;
  logic [COMP_DATA_BITS-1:0]               piv_data_reg;
  logic [AME_ROWS-1:0][COMP_DATA_BITS-1:0] col_data;
  logic [AME_ROWS-1:0]                     idx_onehot;
  logic                                    idle, in_cmp, pivot_bad, handshake;

  assign idle       = (state_reg == ST_IDLE);
  assign in_cmp     = (state_reg == ST_ISSUE) || (state_reg == ST_WAIT);
  assign handshake  = (state_reg == ST_OUT) && piv_valid_reg && piv_ready_i;

  // An out-of-range index shifts to zero here, so it never aliases a real row.
  assign idx_onehot = AME_ROWS'(1) << comp_data_index_i;
  assign pivot_bad  = (comp_data_i == '0) || (comp_data_index_i > LAST_COL)
                      || ((mask_reg & idx_onehot) != '0);

  ame_pivot_mat #(
    .COMP_DATA_BITS    (COMP_DATA_BITS),
    .COMP_DATA_IDX_BITS(COMP_DATA_IDX_BITS)
  ) u_mat (
    .clk    (clk_i),
    .idle   (idle),
    .wr_en  (col_wr_en_i),
    .wr_idx (col_wr_idx_i),
    .wr_data(col_wr_data_i),
    .rd_idx (col_cnt_reg),
    .rd_data(col_data)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (sched_init_i) state_next = ST_ISSUE;
      ST_ISSUE,
      ST_WAIT: begin
        if (comp_done_i) state_next = pivot_bad ? ST_DONE : ST_OUT;
        else             state_next = ST_WAIT;
      end
      ST_OUT:   if (handshake) state_next = (col_cnt_reg == LAST_COL) ? ST_DONE : ST_ISSUE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= ST_IDLE;
      col_cnt_reg   <= '0;
      mask_reg      <= '0;
      singular_reg  <= 1'b0;
      piv_valid_reg <= 1'b0;
      piv_col_reg   <= '0;
      piv_row_reg   <= '0;
      piv_data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (sched_init_i) begin
            col_cnt_reg  <= '0;
            mask_reg     <= '0;
            singular_reg <= 1'b0;
          end
        end
        ST_ISSUE,
        ST_WAIT: begin
          if (comp_done_i) begin
            piv_col_reg  <= col_cnt_reg;
            piv_row_reg  <= comp_data_index_i;
            piv_data_reg <= comp_data_i;
            if (pivot_bad) singular_reg <= 1'b1;
          end
        end
        ST_OUT: begin
          // Valid is staged one cycle behind the capture to keep the wide
          // comparator result path off the downstream interface.
          if (!piv_valid_reg) begin
            piv_valid_reg <= 1'b1;
          end else if (piv_ready_i) begin
            piv_valid_reg <= 1'b0;
            mask_reg      <= mask_reg | (AME_ROWS'(1) << piv_row_reg);
            col_cnt_reg   <= col_cnt_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef AME_PIVOT_PERM_EN
  for (genvar gi = 0; gi < AME_ROWS; gi++) begin : g_perm
    logic [COMP_DATA_IDX_BITS-1:0] entry_reg;
    always_ff @(posedge clk_i) begin
      if (rst_i || (idle && sched_init_i)) begin
        entry_reg <= COMP_DATA_IDX_BITS'(gi);
      end else if (handshake && (piv_col_reg == COMP_DATA_IDX_BITS'(gi))) begin
        entry_reg <= piv_row_reg;
      end
    end
    assign perm_o[gi] = entry_reg;
  end
`endif

  assign sched_busy_o     = !idle;
  assign sched_done_o     = (state_reg == ST_DONE);
  assign sched_singular_o = singular_reg;
  assign comp_init_o      = (state_reg == ST_ISSUE);
  assign comp_data_o      = in_cmp ? col_data : '0;
  assign comp_data_mask_o = in_cmp ? mask_reg : '0;
  assign piv_valid_o      = piv_valid_reg;
  assign piv_col_o        = piv_col_reg;
  assign piv_row_o        = piv_row_reg;
  assign piv_data_o       = piv_data_reg;

endmodule

// File: tb/tb_ame_pivot_sched.sv
// Directed bench for ame_pivot_sched: max-|x| comparator model, pivot scoreboard.
module tb_ame_pivot_sched;
  import ame_pivot_pkg::*;

  localparam int DB = AME_DATA_BITS;
  localparam int IB = 3;

  typedef struct packed { logic [IB-1:0] idx; logic [DB-1:0] val; } pick_t;
  typedef struct packed { logic [IB-1:0] col; logic [IB-1:0] row; logic [DB-1:0] val; } piv_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic pass, input logic [383:0] obs, input logic [383:0] exp);
    checks++;
    if (pass !== 1'b1) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic                       clk_i = 1'b0;
  logic                       rst_i;
  logic                       col_wr_en_i;
  logic [IB-1:0]              col_wr_idx_i;
  column_t                    col_wr_data_i;
  logic                       sched_init_i;
  logic                       sched_busy_o, sched_done_o, sched_singular_o;
  logic                       comp_init_o;
  column_t                    comp_data_o;
  logic [AME_ROWS-1:0]        comp_data_mask_o;
  logic                       comp_done_i;
  logic [DB-1:0]              comp_data_i;
  logic [IB-1:0]              comp_data_index_i;
  logic                       piv_valid_o, piv_ready_i;
  logic [IB-1:0]              piv_col_o, piv_row_o;
  logic [DB-1:0]              piv_data_o;
`ifdef AME_PIVOT_PERM_EN
  logic [AME_ROWS-1:0][IB-1:0] perm_o;
  logic [AME_ROWS-1:0][IB-1:0] exp_perm;
`endif

  always #5 clk_i = ~clk_i;

  ame_pivot_sched #(.COMP_DATA_BITS(DB), .COMP_DATA_IDX_BITS(IB)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .col_wr_en_i      (col_wr_en_i),
    .col_wr_idx_i     (col_wr_idx_i),
    .col_wr_data_i    (col_wr_data_i),
    .sched_init_i     (sched_init_i),
    .sched_busy_o     (sched_busy_o),
    .sched_done_o     (sched_done_o),
    .sched_singular_o (sched_singular_o),
    .comp_init_o      (comp_init_o),
    .comp_data_o      (comp_data_o),
    .comp_data_mask_o (comp_data_mask_o),
    .comp_done_i      (comp_done_i),
    .comp_data_i      (comp_data_i),
    .comp_data_index_i(comp_data_index_i),
`ifdef AME_PIVOT_PERM_EN
    .perm_o           (perm_o),
`endif
    .piv_valid_o      (piv_valid_o),
    .piv_ready_i      (piv_ready_i),
    .piv_col_o        (piv_col_o),
    .piv_row_o        (piv_row_o),
    .piv_data_o       (piv_data_o)
  );

  // Comparator: max |x| among unmasked rows, lowest row on ties; optional fault injection.
  function automatic logic [DB-1:0] mag(input logic [DB-1:0] v);
    return v[DB-1] ? (~v + 1'b1) : v;
  endfunction

  function automatic pick_t pick(input column_t c, input logic [AME_ROWS-1:0] m, input int fmode);
    pick_t p;
    logic found;
    logic [DB-1:0] best;
    p = '0; found = 1'b0; best = '0;
    for (int r = 0; r < AME_ROWS; r++) begin
      if (!m[r] && (!found || mag(c[r]) > best)) begin
        found = 1'b1; best = mag(c[r]); p.idx = IB'(r); p.val = c[r];
      end
    end
    if (fmode == 1) begin
      p.idx = 3'd7; p.val = 64'd1;
    end else if (fmode == 2) begin
      p.idx = 3'd0; p.val = c[0];
    end
    return p;
  endfunction

  int    comp_lat = 0;
  int    force_mode = 0;
  logic  pend;
  int    lat_cnt;
  pick_t cmp_res;

  always @(posedge clk_i) begin
    if (rst_i) begin
      pend <= 1'b0;
      lat_cnt <= 0;
    end else if (comp_init_o && comp_lat != 0) begin
      pend <= 1'b1;
      lat_cnt <= comp_lat - 1;
    end else if (pend) begin
      if (lat_cnt == 0) pend <= 1'b0;
      else lat_cnt <= lat_cnt - 1;
    end
  end

  always_comb begin
    cmp_res           = pick(comp_data_o, comp_data_mask_o, force_mode);
    comp_done_i       = (comp_lat == 0) ? comp_init_o : (pend && lat_cnt == 0);
    comp_data_i       = cmp_res.val;
    comp_data_index_i = cmp_res.idx;
  end

  column_t             tb_mat [AME_ROWS];
  piv_t                exp_q [$];
  logic [AME_ROWS-1:0] issue_mask [256];
  int                  issue_cnt = 0;
  logic                hold_prev = 1'b0;
  piv_t                prev_piv;
  int                  stall_col = -1;
  int                  stall_n = 0;
  logic                exp_sing;

  // Reference: greedy partial pivoting over the bench's own copy of the matrix.
  task automatic model_run();
    logic [AME_ROWS-1:0] m;
    pick_t p;
    piv_t e;
    m = '0;
    exp_sing = 1'b0;
`ifdef AME_PIVOT_PERM_EN
    for (int i = 0; i < AME_ROWS; i++) exp_perm[i] = IB'(i);
`endif
    for (int c = 0; c < AME_ROWS; c++) begin
      p = pick(tb_mat[c], m, force_mode);
      if (p.val == '0 || p.idx > 3'd5 || m[p.idx]) begin
        exp_sing = 1'b1;
        break;
      end
      e.col = IB'(c); e.row = p.idx; e.val = p.val;
      exp_q.push_back(e);
      m[p.idx] = 1'b1;
`ifdef AME_PIVOT_PERM_EN
      exp_perm[c] = p.idx;
`endif
    end
  endtask

  task automatic monitor();
    piv_t e;
    if (rst_i) begin
      hold_prev = 1'b0;
      return;
    end
    if (comp_init_o) begin
      issue_mask[issue_cnt % 256] = comp_data_mask_o;
      issue_cnt++;
    end
    if (piv_valid_o) begin
      if (hold_prev) begin
        chk("hold_col", piv_col_o === prev_piv.col, piv_col_o, prev_piv.col);
        chk("hold_row", piv_row_o === prev_piv.row, piv_row_o, prev_piv.row);
        chk("hold_data", piv_data_o === prev_piv.val, piv_data_o, prev_piv.val);
      end
      if (!piv_ready_i) chk("stall_no_issue", comp_init_o === 1'b0, comp_init_o, 1'b0);
      if (piv_ready_i) begin
        chk("sb_nonempty", (exp_q.size() > 0) === 1'b1, (exp_q.size() > 0), 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("piv_col", piv_col_o === e.col, piv_col_o, e.col);
          chk("piv_row", piv_row_o === e.row, piv_row_o, e.row);
          chk("piv_data", piv_data_o === e.val, piv_data_o, e.val);
          $display("pivot col=%0d row=%0d data=%0d", piv_col_o, piv_row_o, $signed(piv_data_o));
        end
      end
      hold_prev = !piv_ready_i;
      prev_piv.col = piv_col_o; prev_piv.row = piv_row_o; prev_piv.val = piv_data_o;
    end else begin
      hold_prev = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
    monitor();
    @(posedge clk_i);
    #1;
    if (stall_col < 0) begin
      piv_ready_i = 1'b1;
    end else if (piv_valid_o && int'(piv_col_o) == stall_col && stall_n < 5) begin
      piv_ready_i = 1'b0;
      stall_n++;
    end else begin
      piv_ready_i = 1'b1;
    end
  endtask

  task automatic load_col(input int idx, input column_t d);
    col_wr_idx_i = IB'(idx);
    col_wr_data_i = d;
    col_wr_en_i = 1'b1;
    tick();
    col_wr_en_i = 1'b0;
    if (idx < AME_ROWS) tb_mat[idx] = d;
  endtask

  task automatic start_run();
    model_run();
    sched_init_i = 1'b1;
    tick();
    sched_init_i = 1'b0;
  endtask

  task automatic wait_done(input int exp_cyc, input int poke_cyc);
    int cyc;
    cyc = 1;
    while (!sched_done_o && cyc < 400) begin
      if (cyc == poke_cyc) begin
        sched_init_i = 1'b1; col_wr_en_i = 1'b1; col_wr_idx_i = '0; col_wr_data_i = '1;
      end
      tick();
      sched_init_i = 1'b0; col_wr_en_i = 1'b0;
      cyc++;
    end
    chk("done_pulse", sched_done_o === 1'b1, sched_done_o, 1'b1);
    if (exp_cyc > 0) chk("done_cycle", cyc === exp_cyc, cyc, exp_cyc);
    chk("singular", sched_singular_o === exp_sing, sched_singular_o, exp_sing);
    chk("sb_empty", exp_q.size() === 0, exp_q.size(), 0);
`ifdef AME_PIVOT_PERM_EN
    chk("perm", perm_o === exp_perm, perm_o, exp_perm);
`endif
    tick();
    chk("done_one_cycle", sched_done_o === 1'b0, sched_done_o, 1'b0);
    chk("idle_after_done", sched_busy_o === 1'b0, sched_busy_o, 1'b0);
    chk("singular_sticky", sched_singular_o === exp_sing, sched_singular_o, exp_sing);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_busy"}, sched_busy_o === 1'b0, sched_busy_o, 1'b0);
    chk({tag, "_done"}, sched_done_o === 1'b0, sched_done_o, 1'b0);
    chk({tag, "_singular"}, sched_singular_o === 1'b0, sched_singular_o, 1'b0);
    chk({tag, "_comp_init"}, comp_init_o === 1'b0, comp_init_o, 1'b0);
    chk({tag, "_comp_data"}, comp_data_o === column_t'(0), comp_data_o, column_t'(0));
    chk({tag, "_mask"}, comp_data_mask_o === 6'b0, comp_data_mask_o, 6'b0);
    chk({tag, "_valid"}, piv_valid_o === 1'b0, piv_valid_o, 1'b0);
    chk({tag, "_piv_col"}, piv_col_o === 3'd0, piv_col_o, 3'd0);
    chk({tag, "_piv_row"}, piv_row_o === 3'd0, piv_row_o, 3'd0);
    chk({tag, "_piv_data"}, piv_data_o === 64'd0, piv_data_o, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    column_t d;
    int base;
    int n;

    rst_i = 1'b1; col_wr_en_i = 1'b0; col_wr_idx_i = '0; col_wr_data_i = '0;
    sched_init_i = 1'b0; piv_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check_quiet("reset");
    rst_i = 1'b0;

    // Identity, diag 1..6; last column written in the same cycle as the start.
    for (int c = 0; c < 5; c++) begin
      d = '0; d[c] = DB'(c + 1); load_col(c, d);
    end
    d = '0; d[5] = 64'd6;
    col_wr_idx_i = 3'd5; col_wr_data_i = d; col_wr_en_i = 1'b1; tb_mat[5] = d;
    start_run();
    col_wr_en_i = 1'b0;
    wait_done(19, 0);

    // Negative pivot, then a masked maximum; comparator latency 2.
    d = '0; d[0] = -64'd9; d[1] = 64'd3; load_col(0, d);
    d = '0; d[0] = 64'd8; d[1] = 64'd5; d[2] = 64'd1; load_col(1, d);
    for (int c = 2; c < 6; c++) begin
      d = '0; d[c] = DB'(c + 5); load_col(c, d);
    end
    comp_lat = 2;
    base = issue_cnt;
    start_run();
    wait_done(-1, 0);
    chk("c1_mask", issue_mask[(base + 1) % 256] === 6'b000001, issue_mask[(base + 1) % 256], 6'b000001);
    chk("c0_mask", issue_mask[base % 256] === 6'b000000, issue_mask[base % 256], 6'b000000);

    // Zero column 2: singular abort after two pivots.
    comp_lat = 0;
    d = '0; d[0] = 64'd3; d[1] = -64'd9; load_col(0, d);
    d = '0; load_col(2, d);
    start_run();
    wait_done(-1, 0);
    start_run();
    chk("singular_cleared_on_start", sched_singular_o === 1'b0, sched_singular_o, 1'b0);
    wait_done(-1, 0);

    // Downstream stall of five cycles at column 3.
    d = '0; d[2] = 64'd7; load_col(2, d);
    stall_col = 3; stall_n = 0;
    start_run();
    wait_done(-1, 0);
    chk("stall_cycles", stall_n === 5, stall_n, 5);
    stall_col = -1;

    // Reset while column 4 waits on a slow comparator, then rerun from retained matrix.
    comp_lat = 3;
    base = issue_cnt;
    start_run();
    n = 0;
    while (!((issue_cnt - base) == 5 && !comp_init_o) && n < 300) begin
      tick(); n++;
    end
    chk("reached_c4_wait", (issue_cnt - base) === 5, issue_cnt - base, 5);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    check_quiet("abort");
    exp_q.delete();
    hold_prev = 1'b0;
    rst_i = 1'b0;
    comp_lat = 0;
    tick();
    start_run();
    wait_done(19, 0);

    // Out-of-range write in idle and start/write pokes while busy change nothing.
    d = '1; load_col(6, d);
    start_run();
    wait_done(19, 5);
    start_run();
    wait_done(19, 0);

    // Comparator protocol errors: index 7, then an already-used row.
    force_mode = 1;
    start_run();
    wait_done(-1, 0);
    force_mode = 2;
    start_run();
    wait_done(-1, 0);
    force_mode = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ame_pivot_sched.md
Name: ame_pivot_sched

Overview:
- Sequential pivot scheduler for the 6x6 Gaussian-elimination solve in AME.
- Holds the coefficient matrix columns and walks columns 0..5.
- For each column it issues the column to the combinational pivot comparator with a mask of rows already consumed, and captures the returned pivot row.
- It hands each (column, row, value) to the downstream elimination stage over a valid/ready handshake, and flags a singular system.

Parameters:
- COMP_DATA_BITS, 64: coefficient width, two's complement.
- COMP_DATA_IDX_BITS, 3: row/column index width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- col_wr_en_i  in  1  load one matrix column; accepted only in IDLE.
- col_wr_idx_i  in  COMP_DATA_IDX_BITS  column being loaded, 0..5.
- col_wr_data_i  in  6xCOMP_DATA_BITS  column data, row r in element r.
- sched_init_i  in  1  start pulse; accepted only in IDLE.
- sched_busy_o  out  1  high outside IDLE.
- sched_done_o  out  1  one-cycle pulse on completion or abort.
- sched_singular_o  out  1  sticky until next accepted sched_init_i; set when a pivot value is zero.
- comp_init_o  out  1  one-cycle request to the comparator.
- comp_data_o  out  6xCOMP_DATA_BITS  current column.
- comp_data_mask_o  out  6  used-row mask.
- comp_done_i  in  1  comparator result valid.
- comp_data_i  in  COMP_DATA_BITS  signed pivot value, unmodified.
- comp_data_index_i  in  COMP_DATA_IDX_BITS  pivot row.
- piv_valid_o  out  1  pivot available downstream.
- piv_ready_i  in  1  downstream accept.
- piv_col_o  out  COMP_DATA_IDX_BITS  column of pivot.
- piv_row_o  out  COMP_DATA_IDX_BITS  selected row.
- piv_data_o  out  COMP_DATA_BITS  signed pivot value.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, column counter 0, mask 0, singular 0. The matrix store is not cleared.
- FSM states: IDLE, ISSUE, WAIT, OUT, DONE.
- IDLE:
  - col_wr_en_i writes column col_wr_idx_i; indices above 5 are ignored.
  - sched_init_i moves to ISSUE, clears the mask, column counter and singular flag.
  - If col_wr_en_i and sched_init_i arrive together, the write takes effect first, then the start.
- ISSUE:
  - comp_init_o=1 for exactly one cycle.
  - comp_data_o = column[counter]; comp_data_mask_o = mask.
  - Goes to WAIT.
- WAIT:
  - comp_data_o and comp_data_mask_o are held stable.
  - On comp_done_i, register index and value.
  - Value == 0 sets singular and goes to DONE; otherwise goes to OUT.
  - comp_done_i coincident with comp_init_o (zero-latency comparator) is legal: ISSUE then samples it and moves directly to OUT/DONE. The minimum per-column cost is therefore 2 cycles plus the handshake.
- OUT:
  - piv_valid_o=1 with col/row/data held until piv_ready_i.
  - On handshake, set mask[row] and increment the counter.
  - Counter reaching 6 goes to DONE; otherwise goes to ISSUE.
  - piv_ready_i outside OUT is ignored.
- DONE:
  - sched_done_o=1 for one cycle, then IDLE.
  - Latency with ready tied high and a zero-latency comparator: 6x3 cycles + 1 from start to done.
- sched_init_i and col_wr_en_i while busy are ignored, without error.
- Reset mid-operation aborts immediately: no done pulse, valid drops next cycle.
- A returned index that is already masked or above 5 is a protocol error. It is treated as singular and aborted.

Optional Feature:
- Macro: AME_PIVOT_PERM_EN.
- When defined, adds output perm_o (6xCOMP_DATA_IDX_BITS):
  - perm_o[c] = pivot row chosen for column c.
  - Updated at each OUT handshake; reset to the identity 0..5.
  - Valid from the done pulse until the next accepted start.
  - On singular abort, unfilled entries keep their identity values.
- When not defined, the port and its registers are absent and behaviour is otherwise identical.

Decomposition:
- Package ame_pivot_pkg holds:
  - AME_ROWS=6;
  - state enum typedef;
  - column typedef logic [5:0][COMP_DATA_BITS-1:0].
- One sub-module, ame_pivot_mat, is natural: the 6-column register store with IDLE-gated write port and column read mux.
- FSM, mask and counter stay in the top module.

Test Plan:
- Identity with diag 1..6, comparator returns max-|x| unmasked row, ready=1 -> pivots (c0,r0,1)..(c5,r5,6), done at cycle 19, singular=0.
- Column 0 = {-9,3,0,0,0,0}, column 1 with max at row 0 -> c0 picks r0 value -9. Mask 000001 is presented for c1, so c1 picks the best unmasked row.
- Column 2 all zeros -> pivots for c0, c1 only; singular=1; done pulse; perm_o[2..5]=2..5 if enabled.
- piv_ready_i low for 5 cycles at c3 -> valid, col=3, row, data held constant; no further comp_init_o until the handshake.
- rst_i asserted in WAIT of c4 -> next cycle all outputs 0, IDLE. A following start reruns from c0 using the retained matrix.
- sched_init_i and col_wr_en_i pulsed while busy -> no effect on pivots or matrix contents.
